// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and constants for the 1-bit comparator self-test
package cmp_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

    localparam int NVEC = 4;

    // Expected {gt,eq,lt} per vector index k = {a,b}, listed k3..k0
    localparam logic [NVEC-1:0][2:0] EXP_TBL = {3'b010, 3'b100, 3'b001, 3'b010};

endpackage

// File: rtl/cmp_bist.sv
// cmp_bist: built-in self-test sequencer that walks a 1-bit comparator through all operand pairs
module cmp_bist
    import cmp_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int LOOPS      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       lt_i,
    input  logic       eq_i,
    input  logic       gt_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [7:0] err_cnt
);

    state_t     state, state_d;
    logic [1:0] idx, idx_d;
    logic [7:0] loop, loop_d;
    logic [3:0] scnt, scnt_d;
    logic [3:0] fv_d;
    logic [7:0] ec_d;
    logic       pass_d;
    logic       mis;
    logic       drv_d;

    // Any flag pattern other than the one-hot expected word is a mismatch
    assign mis   = {gt_i, eq_i, lt_i} != EXP_TBL[idx];
    assign busy  = state == DRIVE || state == SETTLE || state == SAMPLE;
    assign done  = state == DONE;
    assign drv_d = state_d == DRIVE || state_d == SETTLE || state_d == SAMPLE;

    // Next-state, counter and result logic
    always_comb begin
        state_d = state;
        idx_d   = idx;
        loop_d  = loop;
        scnt_d  = scnt;
        fv_d    = fail_vec;
        ec_d    = err_cnt;
        pass_d  = pass;
        case (state)
            IDLE: if (start) begin
                state_d = DRIVE;
                idx_d   = 2'd0;
                loop_d  = 8'd0;
                fv_d    = 4'd0;
                ec_d    = 8'd0;
                pass_d  = 1'b0;
            end
            DRIVE: begin
                state_d = SETTLE;
                scnt_d  = 4'(SETTLE_CYC - 1);
            end
            SETTLE: begin
                state_d = scnt == 4'd0 ? SAMPLE : SETTLE;
                scnt_d  = scnt == 4'd0 ? scnt : scnt - 4'd1;
            end
            SAMPLE: begin
                if (mis) begin
                    fv_d[idx] = 1'b1;
                    ec_d      = err_cnt == 8'hff ? err_cnt : err_cnt + 8'd1;
                end
                if (idx != 2'(NVEC - 1)) begin
                    idx_d   = idx + 2'd1;
                    state_d = DRIVE;
                end else if (loop < 8'(LOOPS - 1)) begin
                    idx_d   = 2'd0;
                    loop_d  = loop + 8'd1;
                    state_d = DRIVE;
                end else begin
                    state_d = DONE;
                    pass_d  = ec_d == 8'd0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters, results and registered stimulus operands
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            loop     <= 8'd0;
            scnt     <= 4'd0;
            fail_vec <= 4'd0;
            err_cnt  <= 8'd0;
            pass     <= 1'b0;
            a_o      <= 1'b0;
            b_o      <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            loop     <= loop_d;
            scnt     <= scnt_d;
            fail_vec <= fv_d;
            err_cnt  <= ec_d;
            pass     <= pass_d;
            a_o      <= drv_d ? idx_d[1] : 1'b0;
            b_o      <= drv_d ? idx_d[0] : 1'b0;
        end
    end

endmodule

// File: tb/tb_cmp_bist.sv
// tb_cmp_bist: scoreboard bench driving three BIST instances against faulty and healthy comparator models
module tb_cmp_bist;

    typedef struct {
        logic       p;
        logic [3:0] fv;
        logic [7:0] ec;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [2:0] a, b, lt, eq, gt, busy, done, pass;
    logic [3:0] fv [3];
    logic [7:0] ec [3];
    int         m0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       q [3][$];

    always #5 clk = ~clk;

    // Edge counter used to time done pulses
    always @(posedge clk) cyc <= cyc + 1;

    // 1-bit comparator model: 0 healthy, 1 eq stuck 0, 2 lt/gt swapped, 3 all flags stuck 1
    function automatic logic [2:0] model(int mode, logic av, logic bv);
        logic [2:0] f;
        f = {av & ~bv, av == bv, ~av & bv};
        return mode == 1 ? (f & 3'b101) : mode == 2 ? {f[0], f[1], f[2]} : mode == 3 ? 3'b111 : f;
    endfunction

    assign {gt[0], eq[0], lt[0]} = model(m0, a[0], b[0]);
    assign {gt[1], eq[1], lt[1]} = model(2, a[1], b[1]);
    assign {gt[2], eq[2], lt[2]} = model(3, a[2], b[2]);

    cmp_bist #(.SETTLE_CYC(2), .LOOPS(1)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .lt_i(lt[0]), .eq_i(eq[0]), .gt_i(gt[0]),
        .a_o(a[0]), .b_o(b[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_vec(fv[0]), .err_cnt(ec[0])
    );

    cmp_bist #(.SETTLE_CYC(2), .LOOPS(3)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .lt_i(lt[1]), .eq_i(eq[1]), .gt_i(gt[1]),
        .a_o(a[1]), .b_o(b[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_vec(fv[1]), .err_cnt(ec[1])
    );

    cmp_bist #(.SETTLE_CYC(2), .LOOPS(100)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .lt_i(lt[2]), .eq_i(eq[2]), .gt_i(gt[2]),
        .a_o(a[2]), .b_o(b[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .fail_vec(fv[2]), .err_cnt(ec[2])
    );

    task automatic chk(string nm, int got, int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expected result and checks it
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done[d]) begin
                if (q[d].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done dut%0d: got done=1 expected 0 (cycle %0d)", d, cyc);
                end else begin
                    exp_t e;
                    e = q[d].pop_front();
                    chk($sformatf("dut%0d_pass", d), pass[d], e.p);
                    chk($sformatf("dut%0d_fail_vec", d), fv[d], e.fv);
                    chk($sformatf("dut%0d_err_cnt", d), ec[d], e.ec);
                    chk($sformatf("dut%0d_done_cycle", d), cyc, e.cyc);
                    chk($sformatf("dut%0d_busy_at_done", d), busy[d], 0);
                end
            end
        end
    end

    task automatic push(int d, logic p, logic [3:0] f, logic [7:0] e, int dly);
        exp_t x;
        x.p = p;
        x.fv = f;
        x.ec = e;
        x.cyc = cyc + dly;
        q[d].push_back(x);
    endtask

    task automatic run(int d, logic p, logic [3:0] f, logic [7:0] e, int loops);
        push(d, p, f, e, 1 + loops * 16);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_q(int d, int budget);
        int n = 0;
        while (q[d].size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (q[d].size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout dut%0d: %0d done pulses missing after %0d cycles", d, q[d].size(), budget);
            q[d].delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 3'b000;
        m0 = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_busy%0d", d), busy[d], 0);
            chk($sformatf("rst_done%0d", d), done[d], 0);
            chk($sformatf("rst_pass%0d", d), pass[d], 0);
            chk($sformatf("rst_fv%0d", d), fv[d], 0);
            chk($sformatf("rst_ec%0d", d), ec[d], 0);
            chk($sformatf("rst_a%0d", d), a[d], 0);
            chk($sformatf("rst_b%0d", d), b[d], 0);
        end
        rst = 1'b0;
        run(0, 1'b1, 4'b0000, 8'd0, 1);
        chk("busy_after_start", busy[0], 1);
        wait_q(0, 100);
        m0 = 1;
        run(0, 1'b0, 4'b1001, 8'd2, 1);
        wait_q(0, 100);
        m0 = 0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("k2_settle_a", a[0], 1);
        chk("k2_settle_b", b[0], 0);
        chk("k2_settle_busy", busy[0], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_a", a[0], 0);
        chk("midrst_b", b[0], 0);
        chk("midrst_done", done[0], 0);
        chk("midrst_pass", pass[0], 0);
        rst = 1'b0;
        run(0, 1'b1, 4'b0000, 8'd0, 1);
        wait_q(0, 100);
        run(0, 1'b1, 4'b0000, 8'd0, 1);
        repeat (5) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_q(0, 100);
        repeat (25) @(negedge clk);
        push(0, 1'b1, 4'b0000, 8'd0, 17);
        push(0, 1'b1, 4'b0000, 8'd0, 35);
        start[0] = 1'b1;
        repeat (20) @(negedge clk);
        start[0] = 1'b0;
        wait_q(0, 100);
        repeat (25) @(negedge clk);
        run(1, 1'b0, 4'b0110, 8'd6, 3);
        wait_q(1, 200);
        run(2, 1'b0, 4'b1111, 8'd255, 100);
        wait_q(2, 2000);
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
